// File: rtl/mem_handshake_unit_pkg.sv
// Shared definitions for the memory-access stage: FSM encodings, instruction
// field positions and a small address helper.
package mem_handshake_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mh_state_e;

    // Instruction field slices, also used by the multi-cycle controller.
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_handshake_unit_if.sv
// Request/acknowledge bus between the memory-access stage and the unified
// instruction/data memory.
interface mem_handshake_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_ack, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/mem_handshake_unit_wait_timer.sv
// Cycle counter for the WAIT state; term flags the last permitted wait cycle
// (count TIMEOUT-1). TIMEOUT=0 never terminates.
module mem_handshake_unit_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign term = 1'b0;
        end else begin : g_timeout
            assign term = (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_handshake_unit.sv
// Memory-access stage: converts controller strobes into a req/ack memory
// transaction, stalls the controller meanwhile, and owns the IR and MDR.
module mem_handshake_unit
    import mem_handshake_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              IorD,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              stall,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic              err,
    mem_handshake_unit_if.master mbus
);
    mh_state_e         state_q, state_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              err_q, err_d;
    logic              dst_q, dst_d;

    logic              acc, illegal, valid;
    logic [ADDR_W-1:0] sel;
    logic              tmr_clr, tmr_en, tmr_term;

    assign acc     = mem_read | mem_write;
    assign sel     = IorD ? alu_out : pc;
    assign illegal = acc & ((mem_read & mem_write) | ~word_aligned(sel[1:0]));
    assign valid   = acc & ~illegal;

    mem_handshake_unit_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .term(tmr_term)
    );

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        err_d     = err_q;
        dst_d     = dst_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (illegal) begin
                    err_d = 1'b1;
                end else if (valid) begin
                    m_req_d   = 1'b1;
                    m_we_d    = mem_write;
                    m_addr_d  = sel;
                    m_wdata_d = wdata_in;
                    dst_d     = ir_write;
                    tmr_clr   = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                tmr_en = 1'b1;
                // An ack on the terminal cycle still completes the access.
                if (mbus.m_ack) begin
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    if (!m_we_q) begin
                        if (dst_q) ir_d  = mbus.m_rdata;
                        else       mdr_d = mbus.m_rdata;
                    end
                    state_d = S_DONE;
                end else if (tmr_term) begin
                    err_d   = 1'b1;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
            err_q     <= 1'b0;
            dst_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            err_q     <= err_d;
            dst_q     <= dst_d;
        end
    end

    assign stall = ((state_q == S_IDLE) & valid) | (state_q == S_WAIT);

    assign ir     = ir_q;
    assign mdr    = mdr_q;
    assign err    = err_q;
    assign opcode = ir_q[OP_HI:OP_LO];
    assign func   = ir_q[FN_HI:FN_LO];

    assign mbus.m_req   = m_req_q;
    assign mbus.m_we    = m_we_q;
    assign mbus.m_addr  = m_addr_q;
    assign mbus.m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_handshake_unit.sv
// Directed and random transactions against a transaction-level model of the
// memory-access stage (stall length, bus contents, IR/MDR/err outcome).
module tb_mem_handshake_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, IorD, ir_write;
    logic [31:0] pc, alu_out, wdata_in;
    logic        stall, err;
    logic [31:0] ir, mdr;
    logic [5:0]  opcode, func;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [31:0] m_ir, m_mdr;
    logic        m_err;

    mem_handshake_unit_if #(.DATA_W(32), .ADDR_W(32)) mbus ();

    mem_handshake_unit #(
        .DATA_W (32),
        .ADDR_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .IorD     (IorD),
        .ir_write (ir_write),
        .pc       (pc),
        .alu_out  (alu_out),
        .wdata_in (wdata_in),
        .stall    (stall),
        .ir       (ir),
        .mdr      (mdr),
        .opcode   (opcode),
        .func     (func),
        .err      (err),
        .mbus     (mbus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".m_req"}, mbus.m_req, 1'b0);
        check({tag, ".stall"}, stall, 1'b0);
        check({tag, ".ir"}, ir, m_ir);
        check({tag, ".mdr"}, mdr, m_mdr);
        check({tag, ".err"}, err, m_err);
        check({tag, ".opcode"}, opcode, m_ir[31:26]);
        check({tag, ".func"}, func, m_ir[5:0]);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        mem_read = 0; mem_write = 0; IorD = 0; ir_write = 0;
        mbus.m_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ir = '0; m_mdr = '0; m_err = 1'b0;
        @(negedge clk);
        check("rst.m_we", mbus.m_we, 1'b0);
        check("rst.m_addr", mbus.m_addr, 32'h0);
        check("rst.m_wdata", mbus.m_wdata, 32'h0);
        check_state("rst");
        $display("[TB] reset");
    endtask

    // ack_at: WAIT cycle (1-based) in which memory acks; 0 = never.
    task automatic access(input string tag, input logic rd, input logic wr, input logic iord,
                          input logic irw, input logic [31:0] pcv, input logic [31:0] aluv,
                          input logic [31:0] wd, input int ack_at, input logic [31:0] rdata);
        logic [31:0] sel;
        bit acc, fault, got_ack;
        int exp_waits, exp_stall, waits, stalls, cyc;
        sel     = iord ? aluv : pcv;
        acc     = rd | wr;
        fault   = acc && ((rd && wr) || (sel[1:0] != 2'b00));
        got_ack = (ack_at >= 1) && (ack_at <= TO);
        exp_waits = 0;
        exp_stall = 0;
        if (fault) begin
            m_err = 1'b1;
        end else if (acc) begin
            exp_waits = got_ack ? ack_at : TO;
            exp_stall = exp_waits + 1;
            if (!got_ack) m_err = 1'b1;
            else if (rd) begin
                if (irw) m_ir = rdata;
                else     m_mdr = rdata;
            end
        end

        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; IorD = iord; ir_write = irw;
        pc = pcv; alu_out = aluv; wdata_in = wd;
        mbus.m_ack = 0;
        waits = 0; stalls = 0; cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (stall) stalls++;
            if (mbus.m_req) begin
                waits++;
                check({tag, ".m_addr"}, mbus.m_addr, sel);
                check({tag, ".m_we"}, mbus.m_we, wr);
                if (wr) check({tag, ".m_wdata"}, mbus.m_wdata, wd);
            end
            mbus.m_ack   = mbus.m_req && (waits == ack_at);
            mbus.m_rdata = rdata;
        end while (stall && cyc < 40);
        check({tag, ".bound"}, stall, 1'b0);

        @(posedge clk); #1;
        mem_read = 0; mem_write = 0; mbus.m_ack = 0;
        @(negedge clk);
        check({tag, ".stall_cycles"}, stalls, exp_stall);
        check({tag, ".wait_cycles"}, waits, exp_waits);
        check_state(tag);
        $display("[TB] %s rd=%0b wr=%0b addr=%h ack_at=%0d stall=%0d ir=%h mdr=%h err=%0b",
                 tag, rd, wr, sel, ack_at, stalls, ir, mdr, err);
    endtask

    initial begin
        logic        rd, wr, iord;
        logic [31:0] a;
        int          r;
        rst = 1'b1;
        mem_read = 0; mem_write = 0; IorD = 0; ir_write = 0;
        pc = '0; alu_out = '0; wdata_in = '0;
        mbus.m_ack = 0; mbus.m_rdata = '0;
        m_ir = '0; m_mdr = '0; m_err = 1'b0;

        do_reset();

        access("fetch", 1, 0, 0, 1, 32'h10, 32'h0, 32'h0, 1, 32'h8C220004);
        check("fetch.opcode_23", opcode, 6'h23);
        access("load4", 1, 0, 1, 0, 32'h0, 32'h40, 32'h0, 4, 32'hDEADBEEF);
        access("store", 0, 1, 1, 0, 32'h0, 32'h80, 32'h12345678, 2, 32'hFFFF0000);

        do_reset();
        access("both", 1, 1, 1, 0, 32'h0, 32'h40, 32'h0, 1, 32'h11111111);
        do_reset();
        access("misalign", 1, 0, 1, 0, 32'h0, 32'h42, 32'h0, 1, 32'h22222222);

        do_reset();
        access("timeout", 1, 0, 1, 0, 32'h0, 32'h44, 32'h0, 0, 32'h33333333);
        access("refetch", 1, 0, 0, 1, 32'h14, 32'h0, 32'h0, 2, 32'h00851820);

        // Ack while idle must not touch IR/MDR.
        @(posedge clk); #1;
        mbus.m_ack = 1; mbus.m_rdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        mbus.m_ack = 0;
        @(negedge clk);
        check_state("idle_ack");

        for (int i = 0; i < 40; i++) begin
            r    = $urandom_range(0, 9);
            rd   = (r < 5) || (r == 8);
            wr   = (r >= 5 && r < 9);
            iord = 1'($urandom_range(0, 1));
            a    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            access("rand", rd, wr, iord, 1'($urandom_range(0, 1)), a,
                   a ^ 32'h0000_1000, $urandom, $urandom_range(0, 6), $urandom);
        end

        // Reset in the second WAIT cycle, then a late ack.
        @(posedge clk); #1;
        mem_read = 1; ir_write = 1; IorD = 0; pc = 32'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstwait.m_req_before", mbus.m_req, 1'b1);
        rst = 1'b1; mem_read = 0; ir_write = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ir = '0; m_mdr = '0; m_err = 1'b0;
        check("rstwait.m_addr", mbus.m_addr, 32'h0);
        check_state("rstwait");
        mbus.m_ack = 1; mbus.m_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mbus.m_ack = 0;
        @(negedge clk);
        check_state("late_ack");
        $display("[TB] reset mid-WAIT, late ack");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_handshake_unit.md
Name: mem_handshake_unit

Overview:
Memory-access stage between the multi-cycle controller and a single-port, variable-latency unified instruction/data memory.
- Turns the controller's level-style mem_read/mem_write/IorD/ir_write strobes into a req/ack transaction.
- Holds the controller in its current state through a combinational stall.
- Owns the instruction register (IR) and memory data register (MDR), and feeds opcode/func back upstream to the controller.

Parameters:
DATA_W, 32, data and instruction width
ADDR_W, 32, byte address width
TIMEOUT, 16, max WAIT cycles before abort; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
mem_read  in  1  controller read strobe
mem_write  in  1  controller write strobe
IorD  in  1  0: address = pc; 1: address = alu_out
ir_write  in  1  read data goes to IR (1) or MDR (0)
pc  in  ADDR_W  program counter
alu_out  in  ADDR_W  ALUOut register (data address)
wdata_in  in  DATA_W  store data (B register)
stall  out  1  hold controller state register
ir  out  DATA_W  instruction register
mdr  out  DATA_W  memory data register
opcode  out  6  ir[31:26], combinational
func  out  6  ir[5:0], combinational
err  out  1  sticky fault flag
m_req  out  1  memory request
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory byte address
m_wdata  out  DATA_W  memory write data
m_ack  in  1  memory completion, one-cycle pulse
m_rdata  in  DATA_W  read data, valid with m_ack

Behaviour:
- Reset (sync): state=IDLE; m_req=0, m_we=0, m_addr=0, m_wdata=0, ir=0, mdr=0, err=0, wait counter=0.
- Reset mid-transaction aborts immediately with the same values; a late m_ack afterwards is ignored.
- acc = mem_read | mem_write. Selected address sel = IorD ? alu_out : pc.
- FSM states: IDLE, WAIT, DONE.
- IDLE, acc=0: no action; stall=0.
- IDLE, mem_read & mem_write both 1: illegal. Set err, no request, stall=0.
- IDLE, acc=1 and sel[1:0]!=0 (misaligned): set err, no request, stall=0.
- IDLE, valid acc:
  - stall=1 combinationally in this cycle.
  - At the edge: m_req<=1, m_we<=mem_write, m_addr<=sel, m_wdata<=wdata_in; latch ir_write into dst_q; counter<=0; go to WAIT.
- WAIT:
  - stall=1.
  - m_req, m_we, m_addr, m_wdata held stable.
  - counter increments each cycle.
- WAIT, m_ack=1:
  - m_req<=0, m_we<=0.
  - For a read: m_rdata captured into ir if dst_q=1, else into mdr.
  - For a write: nothing captured.
  - Go to DONE.
- WAIT, TIMEOUT!=0 and counter==TIMEOUT-1 without ack: err<=1, m_req<=0, ir/mdr unchanged, go to DONE.
- If m_ack arrives on the timeout cycle, ack wins and err is not set.
- DONE:
  - stall=0, so the controller advances at this edge.
  - The strobes still asserted for the finishing state are ignored.
  - Next state IDLE, unconditionally.
- Latency: each memory-touching controller state lasts minimum 3 cycles (IDLE, WAIT with immediate ack, DONE). Each extra memory wait cycle adds one.
- m_ack outside WAIT is ignored.
- err is sticky until rst; it does not block later accesses.
- stall is purely combinational: (state==IDLE & valid acc) | state==WAIT.

Decomposition:
- Shared package holds:
  - FSM state encodings (IDLE/WAIT/DONE, 2 bits);
  - opcode field slice constants (OP_HI=31, OP_LO=26, FN_HI=5, FN_LO=0), which are reused by the controller.
- One sub-module is natural: wait_timer (counter with clear/enable and a terminal flag at TIMEOUT-1).

Test Plan:
- Fetch:
  - Stimulus: pc=0x00000010, mem_read=1, ir_write=1, IorD=0; ack on 1st WAIT cycle with m_rdata=0x8C220004.
  - Response: m_addr=0x10, stall high 2 cycles, ir=0x8C220004, opcode=0x23, mdr unchanged.
- Load with 4 wait cycles:
  - Stimulus: IorD=1, alu_out=0x00000040, ack after 4 WAIT cycles with data 0xDEADBEEF.
  - Response: m_req held with m_addr=0x40 throughout; mdr=0xDEADBEEF; stall high 5 cycles total.
- Store:
  - Stimulus: mem_write=1, alu_out=0x80, wdata_in=0x12345678.
  - Response: m_we=1, m_wdata=0x12345678 while m_req=1; ir and mdr unchanged after ack.
- Timeout:
  - Stimulus: TIMEOUT=4, no ack.
  - Response: m_req drops after 4 WAIT cycles, err=1, DONE releases stall.
  - A subsequent valid fetch still completes normally.
- Faults:
  - Stimulus: mem_read & mem_write simultaneously, or alu_out=0x42 with IorD=1.
  - Response: err=1, m_req never rises, stall=0.
- Reset mid-WAIT:
  - Stimulus: assert rst in 2nd WAIT cycle, then pulse m_ack.
  - Response: m_req=0, ir=0, state IDLE, late ack ignored.
